// File: rtl/vga_pkg.sv
// vga_pkg: shared field codes, rectangle record and reset layout for the rectangle compositor.
// The rect_t record gains dx/dy velocity fields when RECT_ANIM_EN is defined.
package vga_pkg;

    localparam int VGA_X_W     = 10;
    localparam int VGA_Y_W     = 9;
    localparam int VGA_COLOR_W = 4;
    localparam int VGA_CW      = 3 * VGA_COLOR_W;

    localparam logic [2:0] FLD_X0    = 3'd0;
    localparam logic [2:0] FLD_Y0    = 3'd1;
    localparam logic [2:0] FLD_X1    = 3'd2;
    localparam logic [2:0] FLD_Y1    = 3'd3;
    localparam logic [2:0] FLD_COLOR = 3'd4;
    localparam logic [2:0] FLD_EN    = 3'd5;
    localparam logic [2:0] FLD_VEL   = 3'd6;

    localparam logic [VGA_CW-1:0] CLR_RED   = {{VGA_COLOR_W{1'b1}}, {(2*VGA_COLOR_W){1'b0}}};
    localparam logic [VGA_CW-1:0] CLR_GREEN = {{VGA_COLOR_W{1'b0}}, {VGA_COLOR_W{1'b1}}, {VGA_COLOR_W{1'b0}}};
    localparam logic [VGA_CW-1:0] CLR_BLUE  = {{(2*VGA_COLOR_W){1'b0}}, {VGA_COLOR_W{1'b1}}};

    typedef struct packed {
        logic [VGA_X_W-1:0] x0;
        logic [VGA_Y_W-1:0] y0;
        logic [VGA_X_W-1:0] x1;
        logic [VGA_Y_W-1:0] y1;
        logic [VGA_CW-1:0]  color;
        logic               en;
`ifdef RECT_ANIM_EN
        logic signed [3:0]  dx;
        logic signed [3:0]  dy;
`endif
    } rect_t;

    localparam int RST_X0 [4] = '{120, 200, 280, 360};
    localparam int RST_Y0 [4] = '{40, 120, 200, 280};
    localparam int RST_X1 [4] = '{280, 360, 440, 520};
    localparam int RST_Y1 [4] = '{200, 280, 360, 440};
    localparam logic [VGA_CW-1:0] RST_COLOR [4] = '{CLR_GREEN, CLR_RED, CLR_BLUE, CLR_GREEN};

    // Rectangles beyond the four defaults come up disabled and zeroed.
    function automatic rect_t rst_rect(input int idx);
        rect_t r;
        r = '0;
        if (idx < 4) begin
            r.x0    = VGA_X_W'(RST_X0[idx[1:0]]);
            r.y0    = VGA_Y_W'(RST_Y0[idx[1:0]]);
            r.x1    = VGA_X_W'(RST_X1[idx[1:0]]);
            r.y1    = VGA_Y_W'(RST_Y1[idx[1:0]]);
            r.color = RST_COLOR[idx[1:0]];
            r.en    = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_rect_hit.sv
// vga_rect_hit: strict-bounds hit test of one pixel against one rectangle.
module vga_rect_hit
    import vga_pkg::*;
(
    input  rect_t              i_rect,
    input  logic [VGA_X_W-1:0] i_x,
    input  logic [VGA_Y_W-1:0] i_y,
    output logic               o_hit
);

    assign o_hit = i_rect.en && (i_x > i_rect.x0) && (i_x < i_rect.x1)
                             && (i_y > i_rect.y0) && (i_y < i_rect.y1);

endmodule

// File: rtl/vga_rect_compositor.sv
// vga_rect_compositor: programmable priority rectangle compositor with frame-start shadow commit.
// Define RECT_ANIM_EN to add per-rectangle velocity with edge bounce applied at each commit.
module vga_rect_compositor
    import vga_pkg::*;
#(
    parameter int                     NUM_RECTS = 4,
    parameter int                     X_W       = VGA_X_W,
    parameter int                     Y_W       = VGA_Y_W,
    parameter int                     COLOR_W   = VGA_COLOR_W,
    parameter int                     H_ACTIVE  = 640,
    parameter int                     V_ACTIVE  = 480,
    parameter logic [3*COLOR_W-1:0]   BG_COLOR  = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_stb,
    input  logic [X_W-1:0]     i_x,
    input  logic [Y_W-1:0]     i_y,
    input  logic               i_active,
    input  logic               i_frame_start,
    input  logic               i_wr_valid,
    output logic               o_wr_ready,
    input  logic [3:0]         i_wr_idx,
    input  logic [2:0]         i_wr_field,
    input  logic [15:0]        i_wr_data,
    output logic [COLOR_W-1:0] o_r,
    output logic [COLOR_W-1:0] o_g,
    output logic [COLOR_W-1:0] o_b,
    output logic               o_active
);

    localparam int CW = 3 * COLOR_W;

    rect_t                r_shadow [NUM_RECTS];
    rect_t                r_live   [NUM_RECTS];
    rect_t                w_next   [NUM_RECTS];
    logic [NUM_RECTS-1:0] w_hit;
    logic [NUM_RECTS-1:0] r_hit;
    logic                 r_act1;
    logic                 r_act2;
    logic [CW-1:0]        r_rgb;
    logic [CW-1:0]        w_sel;
    logic                 w_unused;

    assign w_unused   = ^{i_wr_data[15:12], H_ACTIVE[0], V_ACTIVE[0]};
    assign o_wr_ready = ~i_frame_start;

`ifdef RECT_ANIM_EN
    // A move that would leave the visible area reverses that axis instead of moving.
    function automatic rect_t anim_step(input rect_t r);
        logic signed [X_W+1:0] x0n, x1n;
        logic signed [Y_W+1:0] y0n, y1n;
        x0n = $signed({2'b00, r.x0}) + $signed({{(X_W-2){r.dx[3]}}, r.dx});
        x1n = $signed({2'b00, r.x1}) + $signed({{(X_W-2){r.dx[3]}}, r.dx});
        y0n = $signed({2'b00, r.y0}) + $signed({{(Y_W-2){r.dy[3]}}, r.dy});
        y1n = $signed({2'b00, r.y1}) + $signed({{(Y_W-2){r.dy[3]}}, r.dy});
        if (r.en) begin
            if (x0n < 0 || x1n > H_ACTIVE - 1) r.dx = -r.dx;
            else begin
                r.x0 = x0n[X_W-1:0];
                r.x1 = x1n[X_W-1:0];
            end
            if (y0n < 0 || y1n > V_ACTIVE - 1) r.dy = -r.dy;
            else begin
                r.y0 = y0n[Y_W-1:0];
                r.y1 = y1n[Y_W-1:0];
            end
        end
        return r;
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < NUM_RECTS; i++) begin
`ifdef RECT_ANIM_EN
            w_next[i] = anim_step(r_shadow[i]);
`else
            w_next[i] = r_shadow[i];
`endif
        end
    end

    for (genvar g = 0; g < NUM_RECTS; g++) begin : g_hit
        vga_rect_hit u_hit (
            .i_rect (r_live[g]),
            .i_x    (i_x),
            .i_y    (i_y),
            .o_hit  (w_hit[g])
        );
    end

    // Lowest index wins, so scan from the top down and let lower hits overwrite.
    always_comb begin
        w_sel = BG_COLOR;
        for (int i = NUM_RECTS - 1; i >= 0; i--)
            if (r_hit[i]) w_sel = r_live[i].color;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                r_shadow[i] <= rst_rect(i);
                r_live[i]   <= rst_rect(i);
            end
        end else if (i_frame_start) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                r_live[i] <= w_next[i];
`ifdef RECT_ANIM_EN
                r_shadow[i] <= w_next[i];
`endif
            end
        end else if (i_wr_valid) begin
            for (int i = 0; i < NUM_RECTS; i++) begin
                if (i_wr_idx == 4'(i)) begin
                    case (i_wr_field)
                        FLD_X0:    r_shadow[i].x0    <= i_wr_data[X_W-1:0];
                        FLD_Y0:    r_shadow[i].y0    <= i_wr_data[Y_W-1:0];
                        FLD_X1:    r_shadow[i].x1    <= i_wr_data[X_W-1:0];
                        FLD_Y1:    r_shadow[i].y1    <= i_wr_data[Y_W-1:0];
                        FLD_COLOR: r_shadow[i].color <= i_wr_data[CW-1:0];
                        FLD_EN:    r_shadow[i].en    <= i_wr_data[0];
`ifdef RECT_ANIM_EN
                        FLD_VEL: begin
                            r_shadow[i].dx <= i_wr_data[3:0];
                            r_shadow[i].dy <= i_wr_data[7:4];
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit  <= '0;
            r_act1 <= 1'b0;
            r_act2 <= 1'b0;
            r_rgb  <= '0;
        end else if (i_pix_stb) begin
            r_hit  <= w_hit;
            r_act1 <= i_active;
            r_act2 <= r_act1;
            r_rgb  <= r_act1 ? w_sel : '0;
        end
    end

    assign o_r      = r_rgb[3*COLOR_W-1:2*COLOR_W];
    assign o_g      = r_rgb[2*COLOR_W-1:COLOR_W];
    assign o_b      = r_rgb[COLOR_W-1:0];
    assign o_active = r_act2;

endmodule

// File: tb/tb_vga_rect_compositor.sv
// tb_vga_rect_compositor: directed plus randomized checks against a rectangle-list model of the compositor.
module tb_vga_rect_compositor;

    localparam int N = 4;

    typedef struct {
        int x0, y0, x1, y1, col, en;
    } mrect_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_pix_stb = 1'b0;
    logic [9:0]  i_x = '0;
    logic [8:0]  i_y = '0;
    logic        i_active = 1'b0;
    logic        i_frame_start = 1'b0;
    logic        i_wr_valid = 1'b0;
    logic        o_wr_ready;
    logic [3:0]  i_wr_idx = '0;
    logic [2:0]  i_wr_field = '0;
    logic [15:0] i_wr_data = '0;
    logic [3:0]  o_r, o_g, o_b;
    logic        o_active;

    int checks = 0;
    int errors = 0;
    mrect_t sh [N];
    mrect_t lv [N];

    vga_rect_compositor dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_pix_stb     (i_pix_stb),
        .i_x           (i_x),
        .i_y           (i_y),
        .i_active      (i_active),
        .i_frame_start (i_frame_start),
        .i_wr_valid    (i_wr_valid),
        .o_wr_ready    (o_wr_ready),
        .i_wr_idx      (i_wr_idx),
        .i_wr_field    (i_wr_field),
        .i_wr_data     (i_wr_data),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_active      (o_active)
    );

    always #5 i_clk = ~i_clk;

    function automatic mrect_t rst_m(int i);
        case (i)
            0: return '{120, 40, 280, 200, 'h0F0, 1};
            1: return '{200, 120, 360, 280, 'hF00, 1};
            2: return '{280, 200, 440, 360, 'h00F, 1};
            3: return '{360, 280, 520, 440, 'h0F0, 1};
            default: return '{0, 0, 0, 0, 0, 0};
        endcase
    endfunction

    function automatic int model_px(int x, int y, bit act);
        if (!act) return 0;
        for (int i = 0; i < N; i++)
            if (lv[i].en != 0 && x > lv[i].x0 && x < lv[i].x1 && y > lv[i].y0 && y < lv[i].y1)
                return lv[i].col;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh[i] = rst_m(i);
            lv[i] = rst_m(i);
        end
    endtask

    task automatic model_wr(int idx, int field, int data);
        if (idx < N) begin
            case (field)
                0: sh[idx].x0  = data & 'h3FF;
                1: sh[idx].y0  = data & 'h1FF;
                2: sh[idx].x1  = data & 'h3FF;
                3: sh[idx].y1  = data & 'h1FF;
                4: sh[idx].col = data & 'hFFF;
                5: sh[idx].en  = data & 1;
                default: ;
            endcase
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(bit stb, bit fs);
        @(negedge i_clk);
        i_pix_stb     = stb;
        i_frame_start = fs;
        @(posedge i_clk);
        #1;
        i_pix_stb     = 1'b0;
        i_frame_start = 1'b0;
    endtask

    task automatic commit();
        tick(1'b0, 1'b1);
        for (int i = 0; i < N; i++) lv[i] = sh[i];
    endtask

    // Scan one pixel, push a filler pixel behind it, then check the result and that it holds without a strobe.
    task automatic pix(string tag, int x, int y, bit act);
        int exp;
        exp = model_px(x, y, act);
        i_x = 10'(x);
        i_y = 9'(y);
        i_active = act;
        tick(1'b1, 1'b0);
        i_x = 10'($urandom_range(0, 1023));
        i_y = 9'($urandom_range(0, 511));
        i_active = 1'($urandom);
        tick(1'b1, 1'b0);
        chk({tag, ".rgb"}, {o_r, o_g, o_b}, exp);
        chk({tag, ".act"}, o_active, act);
        i_x = 10'($urandom_range(0, 1023));
        i_active = ~i_active;
        tick(1'b0, 1'b0);
        chk({tag, ".hold"}, {o_r, o_g, o_b}, exp);
    endtask

    task automatic wr(int idx, int field, int data);
        bit ok;
        ok = 1'b0;
        @(negedge i_clk);
        i_wr_valid = 1'b1;
        i_wr_idx   = 4'(idx);
        i_wr_field = 3'(field);
        i_wr_data  = 16'(data);
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clk);
            if (o_wr_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wr_ready_timeout", 0, 1);
        else model_wr(idx, field, data);
        #1;
        i_wr_valid = 1'b0;
    endtask

    initial begin
        int d;
        #23;
        chk("rst.rgb", {o_r, o_g, o_b}, 0);
        chk("rst.act", o_active, 0);
        chk("rst.ready", o_wr_ready, 1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();

        pix("green", 150, 100, 1);
        chk("green_const", {o_r, o_g, o_b}, 'h0F0);
        pix("overlap", 240, 160, 1);
        pix("x0_edge", 120, 100, 1);
        pix("bg", 600, 470, 1);
        pix("inactive", 150, 100, 0);
        pix("red", 300, 250, 1);

        wr(1, 4, 'hFFF);
        pix("before_commit", 300, 250, 1);
        commit();
        pix("white", 300, 250, 1);
        chk("white_const", {o_r, o_g, o_b}, 'hFFF);

        // Write raised in the commit cycle must stall and land in the following frame.
        pix("blue", 400, 300, 1);
        @(negedge i_clk);
        i_frame_start = 1'b1;
        i_wr_valid = 1'b1;
        i_wr_idx = 4'd2;
        i_wr_field = 3'd4;
        i_wr_data = 16'hF0F;
        #1;
        chk("fs.ready_low", o_wr_ready, 0);
        @(posedge i_clk);
        for (int i = 0; i < N; i++) lv[i] = sh[i];
        @(negedge i_clk);
        i_frame_start = 1'b0;
        #1;
        chk("fs.ready_high", o_wr_ready, 1);
        @(posedge i_clk);
        model_wr(2, 4, 'hF0F);
        #1;
        i_wr_valid = 1'b0;
        pix("stalled_not_live", 400, 300, 1);
        commit();
        pix("stalled_live", 400, 300, 1);

        wr(0, 0, 300);
        wr(0, 2, 200);
        wr(4, 4, 'hABC);
        wr(4, 5, 0);
        wr(1, 7, 0);
        wr(3, 6, 'h44);
        commit();
        pix("inverted_x", 250, 100, 1);
        pix("inverted_x2", 150, 100, 1);
        pix("idx_oob", 450, 400, 1);

        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < 3; w++) begin
                d = (w == 0) ? int'($urandom & 'hFFFF) : int'($urandom_range(0, 700));
                wr($urandom_range(0, 5), $urandom_range(0, 7), d);
            end
            pix("rnd_pre", $urandom_range(0, 700), $urandom_range(0, 500), 1'($urandom));
            if (it % 2 == 0) commit();
            pix("rnd_post", $urandom_range(100, 540), $urandom_range(30, 450), 1);
        end

        // Reset in the middle of a scan clears the pipeline at once and restores the default layout.
        wr(0, 4, 'h123);
        commit();
        i_x = 10'd150;
        i_y = 9'd100;
        i_active = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("midrst.rgb", {o_r, o_g, o_b}, 0);
        chk("midrst.act", o_active, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        pix("after_rst", 150, 100, 1);
        pix("after_rst2", 400, 300, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
